// File: rtl/layer_controller.sv
// Sequences one conv layer: per filter, load weights, then compute/write every output window.
// Optional per-filter pooling pass is built in when LAYER_CTRL_POOL_EN is defined.
module layer_controller #(
  parameter int FW = 4,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          resetState,
  input  logic          startLayer,
  input  logic [FW-1:0] filterCount,
  input  logic [SW-1:0] outputSize,
  input  logic          dmaReadDone,
  input  logic          computeDone,
  input  logic          dmaWriteDone,
  input  logic          poolDone,
  output logic          loadFilter,
  output logic          startCompute,
  output logic          writeResult,
  output logic          startPool,
  output logic [FW-1:0] filterIdx,
  output logic [SW-1:0] rowIdx,
  output logic [SW-1:0] colIdx,
  output logic          busy,
  output logic          layerFinish
);

`ifdef LAYER_CTRL_POOL_EN
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, POOL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d, filt_q, filt_d;
  logic [SW-1:0] size_q, size_d, row_q, row_d, col_q, col_d;
  logic          load_q, comp_q, write_q, busy_q, fin_q;
  logic          last_col, last_row, last_filt;

  assign last_col  = (col_q == size_q - SW'(1));
  assign last_row  = (row_q == size_q - SW'(1));
  assign last_filt = (filt_q == fcnt_q - FW'(1));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    size_d  = size_q;
    filt_d  = filt_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (startLayer) begin
          fcnt_d  = filterCount;
          size_d  = outputSize;
          filt_d  = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = (filterCount == '0 || outputSize == '0) ? DONE : LOAD;
        end
      end
      LOAD:    if (dmaReadDone) state_d = COMPUTE;
      COMPUTE: if (computeDone) state_d = WRITE;
      WRITE: begin
        if (dmaWriteDone) begin
          state_d = COMPUTE;
          if (!last_col) begin
            col_d = col_q + SW'(1);
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + SW'(1);
            end else begin
              row_d = '0;
`ifdef LAYER_CTRL_POOL_EN
              state_d = POOL;
`else
              if (last_filt) begin
                state_d = DONE;
              end else begin
                filt_d  = filt_q + FW'(1);
                state_d = LOAD;
              end
`endif
            end
          end
        end
      end
`ifdef LAYER_CTRL_POOL_EN
      POOL: begin
        if (poolDone) begin
          if (last_filt) begin
            state_d = DONE;
          end else begin
            filt_d  = filt_q + FW'(1);
            state_d = LOAD;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request outputs are registered from the next state so they are glitch-free Moore flops.
  always_ff @(posedge clk or posedge resetState) begin
    if (resetState) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      size_q  <= '0;
      filt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      load_q  <= 1'b0;
      comp_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      size_q  <= size_d;
      filt_q  <= filt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      load_q  <= (state_d == LOAD);
      comp_q  <= (state_d == COMPUTE);
      write_q <= (state_d == WRITE);
      busy_q  <= (state_d != IDLE);
      fin_q   <= (state_d == DONE);
    end
  end

`ifdef LAYER_CTRL_POOL_EN
  logic pool_q;
  always_ff @(posedge clk or posedge resetState) begin
    if (resetState) pool_q <= 1'b0;
    else            pool_q <= (state_d == POOL);
  end
  assign startPool = pool_q;
`else
  logic unused_pool_done;
  assign unused_pool_done = poolDone;
  assign startPool        = 1'b0;
`endif

  assign loadFilter   = load_q;
  assign startCompute = comp_q;
  assign writeResult  = write_q;
  assign busy         = busy_q;
  assign layerFinish  = fin_q;
  assign filterIdx    = filt_q;
  assign rowIdx       = row_q;
  assign colIdx       = col_q;

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: expected windows are queued at start and checked as COMPUTE requests appear.
module tb_layer_controller;
  localparam int FW = 4;
  localparam int SW = 5;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [SW-1:0] r;
    logic [SW-1:0] c;
  } win_t;

  logic          clk = 1'b0;
  logic          resetState = 1'b1;
  logic          startLayer = 1'b0;
  logic [FW-1:0] filterCount = '0;
  logic [SW-1:0] outputSize = '0;
  logic          dmaReadDone = 1'b0, computeDone = 1'b0, dmaWriteDone = 1'b0, poolDone = 1'b0;
  logic          loadFilter, startCompute, writeResult, startPool, busy, layerFinish;
  logic [FW-1:0] filterIdx;
  logic [SW-1:0] rowIdx, colIdx;

  int   asserts = 0;
  int   fails = 0;
  win_t exp_q[$];

  layer_controller #(.FW(FW), .SW(SW)) dut (
    .clk(clk), .resetState(resetState), .startLayer(startLayer),
    .filterCount(filterCount), .outputSize(outputSize),
    .dmaReadDone(dmaReadDone), .computeDone(computeDone),
    .dmaWriteDone(dmaWriteDone), .poolDone(poolDone),
    .loadFilter(loadFilter), .startCompute(startCompute), .writeResult(writeResult),
    .startPool(startPool), .filterIdx(filterIdx), .rowIdx(rowIdx), .colIdx(colIdx),
    .busy(busy), .layerFinish(layerFinish)
  );

  always #5 clk = ~clk;

  // Runs one layer with an auto-responder that returns each done dly cycles after the request.
  task automatic run_layer(input int fc, input int n, input int dly, input string nm);
    win_t w;
    win_t got;
    int   cnt = 0, loads = 0, pools = 0, exp_loads;
    bit   prev_c = 0, prev_l = 0, prev_p = 0, last_done = 0, finished = 0;
    exp_loads = (fc == 0 || n == 0) ? 0 : fc;
    exp_q.delete();
    for (int f = 0; f < exp_loads; f++)
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          w.f = FW'(f); w.r = SW'(r); w.c = SW'(c);
          exp_q.push_back(w);
        end
    @(negedge clk);
    startLayer = 1'b1; filterCount = FW'(fc); outputSize = SW'(n);
    @(negedge clk);
    startLayer = 1'b0; filterCount = FW'($urandom); outputSize = SW'($urandom);
    for (int k = 1; k <= 3000 && !finished; k++) begin
      if (k == 1) begin
        asserts++;
        if (loadFilter !== (exp_loads != 0)) begin
          fails++; $display("FAIL %s start_to_load: got %b want %b", nm, loadFilter, exp_loads != 0);
        end
      end
      if (layerFinish) begin
        finished = 1;
        asserts++;
        if ((exp_loads == 0 && k != 1) || (exp_loads != 0 && !last_done)) begin
          fails++; $display("FAIL %s finish_latency: finish at cycle %0d, last_done %b", nm, k, last_done);
        end
        asserts++;
        if (exp_q.size() != 0 || loads != exp_loads) begin
          fails++; $display("FAIL %s window_count: %0d windows left, loads %0d want %0d", nm, exp_q.size(), loads, exp_loads);
        end
        asserts++;
`ifdef LAYER_CTRL_POOL_EN
        if (pools != exp_loads) begin
          fails++; $display("FAIL %s pool_count: got %0d want %0d", nm, pools, exp_loads);
        end
`else
        if (pools != 0) begin
          fails++; $display("FAIL %s pool_count: got %0d want 0", nm, pools);
        end
`endif
        asserts++;
        if (busy !== 1'b1 || loadFilter || startCompute || writeResult || startPool) begin
          fails++; $display("FAIL %s done_outputs: busy %b reqs %b%b%b%b", nm, busy, loadFilter, startCompute, writeResult, startPool);
        end
        @(negedge clk);
        asserts++;
        if (layerFinish !== 1'b0 || busy !== 1'b0) begin
          fails++; $display("FAIL %s after_done: finish %b busy %b want 0 0", nm, layerFinish, busy);
        end
      end else begin
        if (startCompute && !prev_c) begin
          asserts++;
          got.f = filterIdx; got.r = rowIdx; got.c = colIdx;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL %s extra_window: got (%0d,%0d,%0d)", nm, got.f, got.r, got.c);
          end else begin
            w = exp_q.pop_front();
            if (got !== w) begin
              fails++; $display("FAIL %s window_idx: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", nm, got.f, got.r, got.c, w.f, w.r, w.c);
            end
          end
        end
        if (loadFilter && !prev_l) begin
          loads++;
          asserts++;
          if (filterIdx !== FW'(loads - 1) || rowIdx !== '0 || colIdx !== '0) begin
            fails++; $display("FAIL %s load_idx: got (%0d,%0d,%0d) want (%0d,0,0)", nm, filterIdx, rowIdx, colIdx, loads - 1);
          end
        end
        if (startPool && !prev_p) pools++;
        prev_c = startCompute; prev_l = loadFilter; prev_p = startPool;
        dmaReadDone = 0; computeDone = 0; dmaWriteDone = 0; poolDone = 0; last_done = 0;
        if (loadFilter || startCompute || writeResult || startPool) begin
          if (cnt >= dly) begin
            cnt = 0;
            dmaReadDone = loadFilter; computeDone = startCompute;
            dmaWriteDone = writeResult; poolDone = startPool;
            last_done = writeResult || startPool;
          end else begin
            cnt++;
          end
        end
        @(negedge clk);
      end
    end
    dmaReadDone = 0; computeDone = 0; dmaWriteDone = 0; poolDone = 0;
    if (!finished) begin
      asserts++; fails++; $display("FAIL %s timeout: no layerFinish within budget", nm);
    end
  endtask

  task automatic test_reset();
    #1;
    asserts++;
    if ({loadFilter, startCompute, writeResult, startPool, busy, layerFinish} !== 6'b0 ||
        filterIdx !== '0 || rowIdx !== '0 || colIdx !== '0) begin
      fails++; $display("FAIL reset_values: reqs %b%b%b%b busy %b fin %b idx (%0d,%0d,%0d)",
        loadFilter, startCompute, writeResult, startPool, busy, layerFinish, filterIdx, rowIdx, colIdx);
    end
    @(negedge clk);
    resetState = 1'b0;
  endtask

  task automatic test_minimal();
    run_layer(1, 1, 2, "minimal");
  endtask

  task automatic test_back_to_back();
    run_layer(2, 2, 0, "b2b_2x2");
    run_layer(3, 3, 1, "b2b_3x3");
  endtask

  task automatic test_zero_count();
    run_layer(0, 3, 0, "zero_filters");
    run_layer(3, 0, 0, "zero_size");
  endtask

  task automatic test_ignored_inputs();
    @(negedge clk); dmaReadDone = 1;
    @(negedge clk); dmaReadDone = 0; computeDone = 1;
    @(negedge clk); computeDone = 0; dmaWriteDone = 1;
    @(negedge clk); dmaWriteDone = 0;
    asserts++;
    if (busy !== 1'b0 || loadFilter !== 1'b0) begin
      fails++; $display("FAIL idle_dones: busy %b load %b want 0 0", busy, loadFilter);
    end
    startLayer = 1; filterCount = 1; outputSize = 1;
    @(negedge clk); startLayer = 0; computeDone = 1; dmaWriteDone = 1;
    @(negedge clk); computeDone = 0; dmaWriteDone = 0; startLayer = 1; filterCount = 3; outputSize = 4;
    @(negedge clk); startLayer = 0;
    asserts++;
    if (loadFilter !== 1'b1 || startCompute !== 1'b0 || filterIdx !== '0) begin
      fails++; $display("FAIL load_ignores: load %b compute %b filt %0d want 1 0 0", loadFilter, startCompute, filterIdx);
    end
    dmaReadDone = 1;
    @(negedge clk); dmaReadDone = 0;
    asserts++;
    if (startCompute !== 1'b1) begin
      fails++; $display("FAIL load_to_compute: compute %b want 1", startCompute);
    end
    dmaReadDone = 1; dmaWriteDone = 1;
    @(negedge clk); dmaReadDone = 0; dmaWriteDone = 0;
    @(negedge clk);
    asserts++;
    if (startCompute !== 1'b1 || writeResult !== 1'b0) begin
      fails++; $display("FAIL compute_ignores: compute %b write %b want 1 0", startCompute, writeResult);
    end
    computeDone = 1;
    @(negedge clk); computeDone = 0; dmaReadDone = 1;
    @(negedge clk); dmaReadDone = 0;
    asserts++;
    if (writeResult !== 1'b1 || layerFinish !== 1'b0) begin
      fails++; $display("FAIL write_ignores: write %b finish %b want 1 0", writeResult, layerFinish);
    end
    dmaWriteDone = 1;
    @(negedge clk); dmaWriteDone = 0;
    asserts++;
    if (layerFinish !== 1'b1) begin
      fails++; $display("FAIL latched_count: finish %b want 1 (count latched as 1)", layerFinish);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    startLayer = 1; filterCount = 2; outputSize = 2;
    @(negedge clk); startLayer = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      dmaReadDone = 0; computeDone = 0; dmaWriteDone = 0;
      if (startCompute && filterIdx == 1 && rowIdx == 1 && colIdx == 0) begin
        hit = 1;
      end else begin
        dmaReadDone = loadFilter; computeDone = startCompute; dmaWriteDone = writeResult;
        @(negedge clk);
      end
    end
    asserts++;
    if (!hit) begin
      fails++; $display("FAIL reset_target: never reached COMPUTE at (1,1,0)");
    end
    resetState = 1;
    #1;
    asserts++;
    if ({loadFilter, startCompute, writeResult, startPool, busy, layerFinish} !== 6'b0 ||
        filterIdx !== '0 || rowIdx !== '0 || colIdx !== '0) begin
      fails++; $display("FAIL midlayer_reset: reqs %b%b%b%b busy %b fin %b idx (%0d,%0d,%0d) want all 0",
        loadFilter, startCompute, writeResult, startPool, busy, layerFinish, filterIdx, rowIdx, colIdx);
    end
    @(negedge clk); resetState = 0;
    run_layer(2, 2, 0, "after_reset");
  endtask

`ifdef LAYER_CTRL_POOL_EN
  task automatic test_pool();
    run_layer(2, 1, 1, "pool_2x1");
  endtask
`endif

  initial begin
    test_reset();
    test_minimal();
    test_back_to_back();
    test_zero_count();
    test_ignored_inputs();
    test_async_reset();
`ifdef LAYER_CTRL_POOL_EN
    test_pool();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/layer_controller.md
# layer_controller

Sequences one convolution layer of the CNN accelerator. On a start pulse from the network-level controller, it walks every output filter. For each filter it loads the weights via DMA, then steps through every output pixel window (compute, then write back), and finally reports layer completion. It sits between the network controller (`startOneLayer`/`oneLayerFinish`) and the DMA engine and convolution datapath.

## Interface
Parameters:
- `FW`, default 4: filter count/index width.
- `SW`, default 5: output-size/row/column index width.

Ports:
- `clk`, in, 1: single clock; all state updates occur on the rising edge.
- `resetState`, in, 1: asynchronous, active-high reset.
- `startLayer`, in, 1: start request; sampled only in IDLE.
- `filterCount`, in, FW: number of filters; latched on start.
- `outputSize`, in, SW: side N of the square N×N output map; latched on start.
- `dmaReadDone`, in, 1: filter-weight load complete.
- `computeDone`, in, 1: current window result ready.
- `dmaWriteDone`, in, 1: result write-back complete.
- `poolDone`, in, 1: pooling pass complete. Used only with `LAYER_CTRL_POOL_EN`.
- `loadFilter`, out, 1: level; high while in LOAD.
- `startCompute`, out, 1: level; high while in COMPUTE.
- `writeResult`, out, 1: level; high while in WRITE.
- `startPool`, out, 1: level; high while in POOL. Tied 0 without the macro.
- `filterIdx`, out, FW: current filter.
- `rowIdx`, out, SW: current output row.
- `colIdx`, out, SW: current output column.
- `busy`, out, 1: high in every state except IDLE.
- `layerFinish`, out, 1: one-cycle pulse in DONE.

## Operation
States and transitions:
- IDLE → DONE if `startLayer` is high and either latched count is 0.
- IDLE → LOAD if `startLayer` is high and both counts are nonzero.
- On the start edge, `filterCount` and `outputSize` are latched and all indices are cleared to 0.
- LOAD → COMPUTE on `dmaReadDone`.
- COMPUTE → WRITE on `computeDone`.
- WRITE → advance on `dmaWriteDone`, with indices updated on the same edge:
  - `colIdx`+1.
  - When the column wraps from N-1: `colIdx`=0 and `rowIdx`+1.
  - When the row also wraps from N-1: the filter's windows are complete.
- After WRITE, if windows remain → COMPUTE.
- After the filter's windows are complete:
  - With the macro → POOL.
  - Without the macro, if more filters remain → LOAD, with `filterIdx`+1 and row/col = 0.
  - Without the macro, on the last filter (`filterIdx`==count-1) → DONE.
- POOL → on `poolDone`, same filter-advance rule as above (next filter → LOAD, last filter → DONE).
- DONE → IDLE unconditionally after 1 cycle.

Boundary rules:
- A done input arriving outside its own wait state is ignored and is not remembered.
- `startLayer` is ignored while `busy` is high.
- Input counts may change during a layer without effect, because they are latched.
- Counters are exact: no index ever reaches N or `filterCount`.
- Total windows per layer = `filterCount`·N·N.

## Timing
- Reset values:
  - State = IDLE.
  - All indices = 0; latched counts = 0.
  - `loadFilter`, `startCompute`, `writeResult`, `startPool`, `layerFinish`, `busy` = 0.
- All outputs are Moore, decoded from the registered state and counters. They are glitch-free relative to `clk`.
- Every handshake is level-held: the request stays high until the done input is sampled high. The state changes on that edge, so the request drops 1 cycle after done.
- Latency:
  - `startLayer` to `loadFilter`: 1 cycle.
  - A done input to the next request: 1 cycle.
  - Final `dmaWriteDone` (or `poolDone`) to `layerFinish`: 1 cycle.
  - Zero-count layer: `layerFinish` 1 cycle after start, `busy` for 1 cycle.
- If a done input is already high on the first cycle of its wait state, it is accepted there. Minimum dwell in each wait state is 1 cycle.
- Asserting `resetState` mid-layer forces IDLE and clears everything immediately (asynchronously). No `layerFinish` is emitted.

## Configuration
- `LAYER_CTRL_POOL_EN` defined:
  - POOL state is present.
  - After each filter's last write, `startPool` is held until `poolDone`.
- `LAYER_CTRL_POOL_EN` undefined:
  - No POOL state; `startPool` = 0.
  - `poolDone` is ignored.
  - The last write of a filter goes directly to LOAD or DONE.

## Test plan
- Minimal layer (count=1, N=1), each done input returned 2 cycles after its request → sequence LOAD, COMPUTE, WRITE, DONE. `layerFinish` is high exactly 1 cycle, then `busy`=0.
- Count=2, N=2, done inputs returned immediately → 8 COMPUTE/WRITE pairs. (row,col) steps (0,0),(0,1),(1,0),(1,1). `filterIdx` goes 0→1 with exactly 2 LOAD phases.
- Count=0 with N=3, then count=3 with N=0 → each gives `layerFinish` 1 cycle after `startLayer`, with no requests asserted.
- `dmaReadDone`/`computeDone`/`dmaWriteDone` pulsed in IDLE and in the wrong states → no state change. A second `startLayer` during a layer → ignored.
- `resetState` asserted while in COMPUTE with (filter,row,col)=(1,1,0) → outputs immediately return to reset values. A subsequent start runs cleanly from (0,0,0).
- With `LAYER_CTRL_POOL_EN`, count=2, N=1 → `startPool` is held after each filter's write until `poolDone`. `layerFinish` follows only the second `poolDone`.
